capture_ctrl: RTL
=================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, sample RAM address width; DEPTH = 2^ADDR_W.
REQ-002 Parameter NUM_CH, default 3, number of 8-bit channels packed in ram_rdata.
REQ-003 Parameter CH_W, default 2, width of dump_ch.
REQ-004 clk  input  1  system clock; the block uses this clock only.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 smpl_en  input  1  one-cycle strobe per ADC sample.
REQ-007 trigger  input  1  one-cycle trigger pulse from the trigger unit.
REQ-008 run_mode  input  2  00 stop, 01 normal, 10 auto, 11 single.
REQ-009 start  input  1  pulse that begins a capture from IDLE.
REQ-010 dec_pwr  input  4  decimation power; keep 1 of every 2^dec_pwr samples.
REQ-011 trig_pos  input  ADDR_W  number of post-trigger samples.
REQ-012 clr_cap_done  input  1  host clears capture_done.
REQ-013 start_dump  input  1  pulse that begins a dump.
REQ-014 dump_ch  input  CH_W  channel to dump.
REQ-015 ram_rdata  input  8*NUM_CH  RAM read data; channel k is bits [8k+7:8k].
REQ-016 dump_rdy  input  1  consumer (UART) ready.
REQ-017 en, we  output  1 each  RAM enable and write enable.
REQ-018 addr  output  ADDR_W  RAM address.
REQ-019 armed  output  1  high while in ARMED.
REQ-020 capture_done  output  1  capture complete flag.
REQ-021 trace_end  output  ADDR_W  address of the last written sample.
REQ-022 dump_data  output  8  dump byte.
REQ-023 dump_vld  output  1  dump_data valid.
REQ-024 dump_done  output  1  one-cycle pulse after the final dump byte.

Function
REQ-025 The state machine SHALL have the states IDLE, PRE, ARMED, POST, DONE, DUMP_RD and DUMP_WAIT.
REQ-026 In IDLE, start with run_mode!=00 SHALL:
- clear the write pointer, the decimation counter and the sample counters;
- transition to PRE.
REQ-027 Decimation: a smpl_en strobe SHALL be kept when dec_cnt==2^dec_pwr-1, then dec_cnt clears; otherwise dec_cnt increments. dec_cnt is 16 bits, and dec_pwr=0 keeps every strobe.
REQ-028 Each kept strobe in PRE, ARMED or POST SHALL produce en=we=1 for exactly one cycle, registered one cycle after the strobe.
- addr equals the write pointer during that cycle.
- The pointer then increments modulo DEPTH, wrapping DEPTH-1 to 0.
REQ-029 PRE SHALL transition to ARMED after DEPTH-trig_pos writes; triggers during PRE are ignored.
REQ-030 ARMED SHALL continue circular writes; a trigger pulse SHALL move to POST on the next clock.
REQ-031 In auto mode (10), entering ARMED SHALL count as a trigger immediately.
REQ-032 POST SHALL write trig_pos samples and then enter DONE; trig_pos=0 enters DONE directly from the trigger.
REQ-033 On DONE entry:
- trace_end latches the last written address;
- capture_done is set;
- armed is 0.
REQ-034 clr_cap_done in DONE SHALL clear capture_done the next cycle and then:
- in normal or auto mode, restart at PRE (pointer cleared);
- in single mode, go to IDLE.
REQ-035 start_dump in DONE SHALL latch dump_ch and start a DEPTH-word read at address trace_end+1 mod DEPTH, the oldest sample.
REQ-036 DUMP_RD SHALL drive en=1, we=0 and addr=read pointer for one cycle; the RAM read latency is 1 cycle.
REQ-037 DUMP_WAIT SHALL present the latched channel byte with dump_vld=1.
- dump_data and dump_vld stay stable until dump_rdy=1.
- On dump_rdy, the read pointer advances.
- dump_ch>=NUM_CH returns 0x00.
REQ-038 After DEPTH words, dump_done SHALL pulse for one cycle, the block SHALL return to DONE, and capture_done SHALL remain 1.
REQ-039 Simultaneous events and ignored inputs:
- start_dump and clr_cap_done together in DONE: start_dump wins and clr is ignored.
- clr_cap_done and start_dump outside DONE are ignored.
- start outside IDLE is ignored.
REQ-040 run_mode=00 in PRE, ARMED or POST SHALL return to IDLE next cycle without setting capture_done; it has no effect during a dump.

Reset
REQ-041 While rst_n=0, at any time including mid-capture or mid-dump:
- state is IDLE;
- all outputs are 0;
- addr, trace_end and the internal counters are 0.

Verification
REQ-042 ADDR_W=4, dec_pwr=0, trig_pos=4, normal mode, smpl_en every cycle, trigger at first armed cycle -> armed after 12 writes, writes at 0..15, capture_done=1, trace_end=15.
REQ-043 Same setup with dec_pwr=2 -> we asserted once per 4 strobes, capture_done after 64 strobes.
REQ-044 Trigger pulses during PRE, then a trigger after 20 writes -> trace_end=7; dump on ch1 reads addr 8..15,0..7, returns ram_rdata[15:8], 16 bytes.
REQ-045 Dump with dump_rdy toggling 1-of-3 cycles -> dump_data stable while dump_vld && !dump_rdy; dump_done pulses once after the 16th byte.
REQ-046 Auto mode, no trigger -> DONE after 16 writes; single mode + clr_cap_done -> IDLE, no further writes.
REQ-047 rst_n low mid-POST -> all outputs 0 immediately; start after release begins writes at addr 0.

Source files
------------

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - pre/post-trigger circular sample capture with single-channel dump
module capture_ctrl #(
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                smpl_en,
    input  logic                trigger,
    input  logic [1:0]          run_mode,
    input  logic                start,
    input  logic [3:0]          dec_pwr,
    input  logic [ADDR_W-1:0]   trig_pos,
    input  logic                clr_cap_done,
    input  logic                start_dump,
    input  logic [CH_W-1:0]     dump_ch,
    input  logic [8*NUM_CH-1:0] ram_rdata,
    input  logic                dump_rdy,
    output logic                en,
    output logic                we,
    output logic [ADDR_W-1:0]   addr,
    output logic                armed,
    output logic                capture_done,
    output logic [ADDR_W-1:0]   trace_end,
    output logic [7:0]          dump_data,
    output logic                dump_vld,
    output logic                dump_done
);

    localparam logic [1:0]        MODE_STOP   = 2'b00;
    localparam logic [1:0]        MODE_NORMAL = 2'b01;
    localparam logic [1:0]        MODE_AUTO   = 2'b10;
    localparam logic [ADDR_W-1:0] A_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_ONE       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_C     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_DUMP_RD, S_DUMP_WAIT
    } state_t;

    state_t            state;
    logic [15:0]       dec_cnt;
    logic [15:0]       dec_max;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   pre_len;
    logic [ADDR_W:0]   post_len;
    logic [ADDR_W:0]   trig_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] last_wr;
    logic [ADDR_W-1:0] oldest;
    logic [CH_W-1:0]   dump_sel;
    logic [7:0]        sel_byte;
    logic              keep;
    logic              fire;

    assign dec_max  = (16'd1 << dec_pwr) - 16'd1;
    assign keep     = smpl_en && (dec_cnt == dec_max);
    assign cnt_inc  = cnt + C_ONE;
    assign pre_len  = DEPTH_C - {1'b0, trig_pos};
    assign post_len = {1'b0, trig_pos};
    // A sample kept in the trigger cycle is the first post-trigger sample.
    assign trig_cnt = keep ? C_ONE : '0;
    assign last_wr  = keep ? wr_ptr : wr_ptr - A_ONE;
    assign oldest   = trace_end + A_ONE;
    assign fire     = trigger || (run_mode == MODE_AUTO);

    always_comb begin
        sel_byte = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(dump_sel) == k) sel_byte = ram_rdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dec_cnt      <= '0;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            dump_sel     <= '0;
            en           <= 1'b0;
            we           <= 1'b0;
            addr         <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            trace_end    <= '0;
            dump_data    <= '0;
            dump_vld     <= 1'b0;
            dump_done    <= 1'b0;
        end else begin
            en        <= 1'b0;
            we        <= 1'b0;
            dump_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && run_mode != MODE_STOP) begin
                        wr_ptr  <= '0;
                        dec_cnt <= '0;
                        cnt     <= '0;
                        state   <= S_PRE;
                    end
                end
                S_PRE, S_ARMED, S_POST: begin
                    if (run_mode == MODE_STOP) begin
                        armed <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (smpl_en) dec_cnt <= keep ? '0 : dec_cnt + 16'd1;
                        if (keep) begin
                            en     <= 1'b1;
                            we     <= 1'b1;
                            addr   <= wr_ptr;
                            wr_ptr <= wr_ptr + A_ONE;
                        end
                        if (state == S_PRE) begin
                            if (keep) begin
                                cnt <= cnt_inc;
                                if (cnt_inc == pre_len) begin
                                    armed <= 1'b1;
                                    state <= S_ARMED;
                                end
                            end
                        end else if (state == S_ARMED) begin
                            if (fire) begin
                                armed <= 1'b0;
                                cnt   <= trig_cnt;
                                if (trig_cnt >= post_len) begin
                                    capture_done <= 1'b1;
                                    trace_end    <= last_wr;
                                    state        <= S_DONE;
                                end else begin
                                    state <= S_POST;
                                end
                            end
                        end else if (keep) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == post_len) begin
                                capture_done <= 1'b1;
                                trace_end    <= last_wr;
                                state        <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (start_dump) begin
                        dump_sel <= dump_ch;
                        rd_ptr   <= oldest;
                        cnt      <= '0;
                        en       <= 1'b1;
                        addr     <= oldest;
                        state    <= S_DUMP_RD;
                    end else if (clr_cap_done) begin
                        capture_done <= 1'b0;
                        if (run_mode == MODE_NORMAL || run_mode == MODE_AUTO) begin
                            wr_ptr  <= '0;
                            dec_cnt <= '0;
                            cnt     <= '0;
                            state   <= S_PRE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DUMP_RD: state <= S_DUMP_WAIT;
                S_DUMP_WAIT: begin
                    // First wait cycle sees the RAM output; the byte is then held until taken.
                    if (!dump_vld) begin
                        dump_vld  <= 1'b1;
                        dump_data <= sel_byte;
                    end else if (dump_rdy) begin
                        dump_vld <= 1'b0;
                        rd_ptr   <= rd_ptr + A_ONE;
                        cnt      <= cnt_inc;
                        if (cnt_inc == DEPTH_C) begin
                            dump_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            en    <= 1'b1;
                            addr  <= rd_ptr + A_ONE;
                            state <= S_DUMP_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
